// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the HI/LO multiply/divide unit.
// The divider datapath is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_STEP_BITS = 1;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one RUN-cycle worth of unsigned shift-add multiply or
// restoring divide, STEP_BITS result bits per call.
// Multiply: {acc, sh} is the partial product, sh starts as the multiplier.
// Divide (only with MULDIV_DIV_EN): acc is the partial remainder, sh starts
// as the dividend and collects quotient bits from the right.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int STEP_BITS = DEF_STEP_BITS
) (
`ifdef MULDIV_DIV_EN
   input  logic              is_div,
`endif
   input  logic [DATA_W-1:0] acc_in,
   input  logic [DATA_W-1:0] sh_in,
   input  logic [DATA_W-1:0] opnd,
   output logic [DATA_W-1:0] acc_out,
   output logic [DATA_W-1:0] sh_out
);

   logic [DATA_W:0]   wide;
   logic [DATA_W-1:0] acc_v;
   logic [DATA_W-1:0] sh_v;

   // Unrolled iteration of STEP_BITS single-bit multiply/divide steps.
   always_comb begin
      acc_v = acc_in;
      sh_v  = sh_in;
      wide  = '0;
      for (int i = 0; i < STEP_BITS; i++) begin
`ifdef MULDIV_DIV_EN
         if (is_div) begin
            wide = {acc_v, sh_v[DATA_W-1]};
            sh_v = {sh_v[DATA_W-2:0], 1'b0};
            if (wide >= {1'b0, opnd}) begin
               wide    = wide - {1'b0, opnd};
               sh_v[0] = 1'b1;
            end else begin
               sh_v[0] = 1'b0;
            end
            acc_v = wide[DATA_W-1:0];
         end else begin
`endif
            if (sh_v[0]) begin
               wide = {1'b0, acc_v} + {1'b0, opnd};
            end else begin
               wide = {1'b0, acc_v};
            end
            sh_v  = {wide[0], sh_v[DATA_W-1:1]};
            acc_v = wide[DATA_W:1];
`ifdef MULDIV_DIV_EN
         end
`endif
      end
      acc_out = acc_v;
      sh_out  = sh_v;
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Signed operations run on magnitudes and fix the signs on the final edge.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete
// immediately and leave HI/LO untouched.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int STEP_BITS = DEF_STEP_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   input  logic              hilo_we,
   input  logic              hilo_sel,
   input  logic [DATA_W-1:0] hilo_wdata,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int N     = DATA_W / STEP_BITS;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   // Conditional two's-complement negate (magnitude / sign restore).
   function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v, input logic s);
      if (s) begin
         return ~v + DATA_W'(1);
      end else begin
         return v;
      end
   endfunction

   state_e              state, state_next;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   acc, sh, opnd, acc_nx, sh_nx, res_hi, res_lo;
   logic [2*DATA_W-1:0] prod;
   logic                neg_lo, is_signed, div_op, last;
`ifdef MULDIV_DIV_EN
   logic                is_div, neg_hi, dbz;
   logic [DATA_W-1:0]   a_hold;
`endif

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
   assign last      = (cnt == CNT_LAST);

   muldiv_step #(.DATA_W(DATA_W), .STEP_BITS(STEP_BITS)) u_step (
`ifdef MULDIV_DIV_EN
      .is_div  (is_div),
`endif
      .acc_in  (acc),
      .sh_in   (sh),
      .opnd    (opnd),
      .acc_out (acc_nx),
      .sh_out  (sh_nx)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush overrides everything, including a new start.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
`ifdef MULDIV_DIV_EN
               state_next = ST_RUN;
`else
               state_next = div_op ? ST_DONE : ST_RUN;
`endif
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         state_next = state_next;
      end
   end

   // Final HI/LO value from the last step: sign fix-up and divide-by-zero result.
   always_comb begin
      prod = {acc_nx, sh_nx};
      if (neg_lo) begin
         prod = ~prod + (2*DATA_W)'(1);
      end else begin
         prod = {acc_nx, sh_nx};
      end
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         if (dbz) begin
            res_hi = a_hold;
            res_lo = {DATA_W{1'b1}};
         end else begin
            res_hi = cneg(acc_nx, neg_hi);
            res_lo = cneg(sh_nx, neg_lo);
         end
      end else begin
         res_hi = prod[2*DATA_W-1:DATA_W];
         res_lo = prod[DATA_W-1:0];
      end
`endif
   end

   // Datapath, HI/LO and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt         <= '0;
         acc         <= '0;
         sh          <= '0;
         opnd        <= '0;
         neg_lo      <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div      <= 1'b0;
         neg_hi      <= 1'b0;
         dbz         <= 1'b0;
         a_hold      <= '0;
`endif
      end else begin
         busy <= (state_next == ST_RUN);
         done <= (state_next == ST_DONE);
`ifdef MULDIV_DIV_EN
         div_by_zero <= (state_next == ST_DONE) && dbz;
`else
         div_by_zero <= 1'b0;
`endif
         if ((state == ST_IDLE) && hilo_we) begin
            if (hilo_sel) begin
               hi <= hilo_wdata;
            end else begin
               lo <= hilo_wdata;
            end
         end
         if (flush) begin
            cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  cnt <= '0;
                  if (start) begin
                     acc    <= '0;
                     neg_lo <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
                     opnd   <= cneg(a, is_signed && a[DATA_W-1]);
                     sh     <= cneg(b, is_signed && b[DATA_W-1]);
`ifdef MULDIV_DIV_EN
                     is_div <= div_op;
                     dbz    <= div_op && (b == '0);
                     neg_hi <= div_op && is_signed && a[DATA_W-1];
                     a_hold <= a;
                     if (div_op) begin
                        opnd <= cneg(b, is_signed && b[DATA_W-1]);
                        sh   <= cneg(a, is_signed && a[DATA_W-1]);
                     end
`endif
                  end
               end
               ST_RUN: begin
                  acc <= acc_nx;
                  sh  <= sh_nx;
                  cnt <= cnt + CNT_W'(1);
                  if (last) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
               ST_DONE: cnt <= '0;
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule
